// File: rtl/conv_pkg.sv
// Image constants shared by the convolution filter and its result writer,
// plus the writer's state encoding.
package conv_pkg;

   localparam int IMG_W   = 256;
   localparam int IMG_H   = 64;
   localparam int NUM_PIX = IMG_W * IMG_H;
   localparam int ADDR_W  = 15;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/wr_fifo.sv
// Small synchronous FIFO that absorbs SRAM grant stalls. Besides full, it exposes
// the head and emptiness as they will be after this edge, so the owner can register them.
module wr_fifo #(
   parameter int W     = 23,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_din,
   output logic         o_full,
   output logic         o_nxt_empty,
   output logic [W-1:0] o_nxt_head
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [PW:0]   r_cnt;
   logic [PW:0]   w_cnt_left;
   logic [PW:0]   w_cnt_nxt;
   logic [PW-1:0] w_rd_nxt;

   assign o_full      = (r_cnt == (PW+1)'(DEPTH));
   assign w_cnt_left  = r_cnt - (PW+1)'(i_pop);
   assign w_cnt_nxt   = i_flush ? '0 : w_cnt_left + (PW+1)'(i_push);
   assign w_rd_nxt    = r_rd + PW'(i_pop);
   assign o_nxt_empty = (w_cnt_nxt == '0);
   // Nothing left after the pop means the new head is the word being pushed now.
   assign o_nxt_head  = (w_cnt_left == '0) ? i_din : r_mem[w_rd_nxt];

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr] <= i_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_wr <= r_wr + 1'b1;
         end
         r_rd  <= w_rd_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/conv_result_writer.sv
// Writes the filter's result stream row-major into the output SRAM through a stall FIFO.
// Optional WRITE_CHECKSUM_EN adds a mod-2^16 sum of committed write data.
//
// state   | meaning
// IDLE    | waiting for start, in_valid ignored
// RUN     | accepting pixels and draining writes, busy=1
// DONE    | frame committed, done=1, waiting for start
module conv_result_writer #(
   parameter int IMG_W      = conv_pkg::IMG_W,
   parameter int NUM_PIX    = conv_pkg::NUM_PIX,
   parameter int BASE_ADDR  = 0,
   parameter int ADDR_W     = conv_pkg::ADDR_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_pixel,
   input  logic              sram_gnt,
   output logic [ADDR_W-1:0] addr,
   output logic              en,
   output logic              wen,
   output logic [7:0]        d,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W-1:0] wr_count
`ifdef WRITE_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   import conv_pkg::*;

   localparam int IDX_W = $clog2(NUM_PIX + 1);

   if ((NUM_PIX % IMG_W) != 0 || NUM_PIX > (1 << ADDR_W)) begin : g_bad_cfg
      $error("conv_result_writer: NUM_PIX must be whole rows and fit the address space");
   end

   logic [1:0]          r_state;
   logic [IDX_W-1:0]    r_in_idx;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_en;
   logic                r_wen;
   logic [7:0]          r_d;
   logic                r_busy;
   logic                r_done;
   logic                r_ovf;
   logic [ADDR_W-1:0]   r_wr_cnt;

   logic                w_run;
   logic                w_arm;
   logic                w_take;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                w_full;
   logic                w_nxt_empty;
   logic [ADDR_W+7:0]   w_entry;
   logic [ADDR_W+7:0]   w_nxt_head;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic                w_frame_end;

   assign w_run       = (r_state == ST_RUN);
   assign w_arm       = start && !w_run;
   assign w_take      = w_run && in_valid && (r_in_idx < IDX_W'(NUM_PIX));
   assign w_pop       = r_en && sram_gnt;
   // A full FIFO still takes the pixel when the head commits in the same cycle.
   assign w_push      = w_take && (!w_full || w_pop);
   assign w_drop      = w_take && w_full && !w_pop;
   assign w_entry     = {ADDR_W'(BASE_ADDR) + ADDR_W'(r_in_idx), in_pixel};
   assign w_idx_nxt   = r_in_idx + IDX_W'(w_take);
   assign w_frame_end = (w_idx_nxt == IDX_W'(NUM_PIX)) && w_nxt_empty;

   wr_fifo #(
      .W     (ADDR_W + 8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (w_arm),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_din       (w_entry),
      .o_full      (w_full),
      .o_nxt_empty (w_nxt_empty),
      .o_nxt_head  (w_nxt_head)
   );

`ifdef WRITE_CHECKSUM_EN
   logic [15:0] r_sum;
   assign checksum = r_sum;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_in_idx <= '0;
         r_addr   <= '0;
         r_en     <= 1'b0;
         r_wen    <= 1'b1;
         r_d      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_wr_cnt <= '0;
`ifdef WRITE_CHECKSUM_EN
         r_sum    <= '0;
`endif
      end else begin
         r_en  <= !w_nxt_empty;
         r_wen <= w_nxt_empty;
         if (!w_nxt_empty) begin
            r_addr <= w_nxt_head[ADDR_W+7:8];
            r_d    <= w_nxt_head[7:0];
         end
         case (r_state)
            ST_RUN: begin
               r_in_idx <= w_idx_nxt;
               if (w_drop) begin
                  r_ovf <= 1'b1;
               end
               if (w_pop) begin
                  r_wr_cnt <= r_wr_cnt + 1'b1;
`ifdef WRITE_CHECKSUM_EN
                  r_sum    <= r_sum + 16'(r_d);
`endif
               end
               if (w_frame_end) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               if (start) begin
                  r_state  <= ST_RUN;
                  r_in_idx <= '0;
                  r_wr_cnt <= '0;
                  r_ovf    <= 1'b0;
                  r_done   <= 1'b0;
                  r_busy   <= 1'b1;
`ifdef WRITE_CHECKSUM_EN
                  r_sum    <= '0;
`endif
               end
            end
         endcase
      end
   end

   assign addr     = r_addr;
   assign en       = r_en;
   assign wen      = r_wen;
   assign d        = r_d;
   assign busy     = r_busy;
   assign done     = r_done;
   assign overflow = r_ovf;
   assign wr_count = r_wr_cnt;

endmodule

// File: tb/tb_conv_result_writer.sv
// Bench for conv_result_writer: a queue-based reference model advanced every clock,
// with scenario tasks comparing DUT outputs against it.
module tb_conv_result_writer;

   localparam int NP   = 100;
   localparam int AW   = 8;
   localparam int BASE = 200;
   localparam int FD   = 4;
   localparam int AMOD = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_pixel;
   logic          sram_gnt;
   logic [AW-1:0] addr;
   logic          en;
   logic          wen;
   logic [7:0]    d;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [AW-1:0] wr_count;
`ifdef WRITE_CHECKSUM_EN
   logic [15:0]   checksum;
`endif

   int n_pass = 0;
   int n_chk  = 0;

   logic [AW+7:0] q[$];
   bit            m_run;
   bit            m_done;
   bit            m_ovf;
   int            m_idx;
   int            m_wr;
   int            m_sum;
   logic [AW+7:0] m_last;

   always #5 clk = ~clk;

   conv_result_writer #(
      .IMG_W      (10),
      .NUM_PIX    (NP),
      .BASE_ADDR  (BASE),
      .ADDR_W     (AW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_pixel (in_pixel),
      .sram_gnt (sram_gnt),
      .addr     (addr),
      .en       (en),
      .wen      (wen),
      .d        (d),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .wr_count (wr_count)
`ifdef WRITE_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   // Advance one clock: update the model from the inputs seen at the edge, then settle.
   task automatic tick();
      logic [AW+7:0] e;
      @(posedge clk);
      if (rst) begin
         q.delete(); m_run = 0; m_done = 0; m_ovf = 0; m_idx = 0; m_wr = 0; m_sum = 0; m_last = '0;
      end else if (!m_run) begin
         if (start) begin
            q.delete(); m_run = 1; m_done = 0; m_ovf = 0; m_idx = 0; m_wr = 0; m_sum = 0;
         end
      end else begin
         if (q.size() > 0 && sram_gnt) begin
            m_wr++;
            m_sum = (m_sum + int'(q[0][7:0])) % 65536;
            void'(q.pop_front());
         end
         if (in_valid && m_idx < NP) begin
            e = {AW'((BASE + m_idx) % AMOD), in_pixel};
            if (q.size() < FD) q.push_back(e);
            else m_ovf = 1;
            m_idx++;
         end
         if (m_idx == NP && q.size() == 0) begin
            m_run = 0; m_done = 1;
         end
      end
      if (q.size() > 0) m_last = q[0];
      #1;
   endtask

   task automatic do_reset();
      rst = 1; start = 0; in_valid = 0; in_pixel = 0; sram_gnt = 0;
      tick(); tick();
      rst = 0;
   endtask

   task automatic arm();
      start = 1; tick(); start = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (en !== 1'b0) $display("FAIL reset_en: got %0b want 0", en); else n_pass++;
      n_chk++; if (wen !== 1'b1) $display("FAIL reset_wen: got %0b want 1", wen); else n_pass++;
      n_chk++; if (addr !== '0) $display("FAIL reset_addr: got %0h want 0", addr); else n_pass++;
      n_chk++; if (d !== 8'h00) $display("FAIL reset_d: got %0h want 0", d); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
      n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", overflow); else n_pass++;
      n_chk++; if (wr_count !== '0) $display("FAIL reset_wrcnt: got %0d want 0", wr_count); else n_pass++;
   endtask

   task automatic test_basic();
      do_reset();
      sram_gnt = 1;
      arm();
      n_chk++; if (busy !== 1'b1) $display("FAIL basic_busy: got %0b want 1", busy); else n_pass++;
      in_valid = 1; in_pixel = 8'h5A;
      tick();
      in_pixel = 8'h00;
      n_chk++; if (en !== 1'b1 || wen !== 1'b0) $display("FAIL basic_en0: got en=%0b wen=%0b want 1/0", en, wen); else n_pass++;
      n_chk++; if (addr !== AW'(BASE) || d !== 8'h5A) $display("FAIL basic_w0: got %0h/%0h want %0h/5a", addr, d, AW'(BASE)); else n_pass++;
      tick();
      in_valid = 0;
      n_chk++; if (en !== 1'b1 || addr !== AW'(BASE + 1) || d !== 8'h00) $display("FAIL basic_w1: got en=%0b %0h/%0h want 1 %0h/00", en, addr, d, AW'(BASE + 1)); else n_pass++;
      tick();
      n_chk++; if (wr_count !== AW'(2)) $display("FAIL basic_wrcnt: got %0d want 2", wr_count); else n_pass++;
      n_chk++; if (en !== 1'b0 || wen !== 1'b1) $display("FAIL basic_idle: got en=%0b wen=%0b want 0/1", en, wen); else n_pass++;
   endtask

   task automatic test_full_frame();
      do_reset();
      sram_gnt = 1;
      arm();
      for (int k = 0; k < NP; k++) begin
         for (int c = 0; c < 27; c++) begin
            in_valid = (c == 0); in_pixel = k[7:0];
            tick();
            n_chk++; if (en !== (q.size() != 0)) $display("FAIL frame_en k=%0d: got %0b want %0b", k, en, q.size() != 0); else n_pass++;
            n_chk++; if (addr !== m_last[AW+7:8] || d !== m_last[7:0]) $display("FAIL frame_wr k=%0d: got %0h/%0h want %0h/%0h", k, addr, d, m_last[AW+7:8], m_last[7:0]); else n_pass++;
            n_chk++; if (done !== m_done) $display("FAIL frame_done k=%0d: got %0b want %0b", k, done, m_done); else n_pass++;
         end
      end
      in_valid = 0;
      n_chk++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL frame_end: got done=%0b busy=%0b want 1/0", done, busy); else n_pass++;
      n_chk++; if (wr_count !== AW'(NP) || overflow !== 1'b0) $display("FAIL frame_cnt: got %0d ovf=%0b want %0d 0", wr_count, overflow, NP); else n_pass++;
      n_chk++; if (addr !== AW'((BASE + NP - 1) % AMOD) || d !== 8'(NP - 1)) $display("FAIL frame_last: got %0h/%0h want %0h/%0h", addr, d, AW'((BASE + NP - 1) % AMOD), 8'(NP - 1)); else n_pass++;
`ifdef WRITE_CHECKSUM_EN
      n_chk++; if (checksum !== 16'(m_sum)) $display("FAIL frame_sum: got %0h want %0h", checksum, 16'(m_sum)); else n_pass++;
`endif
      for (int c = 0; c < 3; c++) begin
         in_valid = 1; in_pixel = 8'hFF;
         tick();
         n_chk++; if (en !== 1'b0 || done !== 1'b1) $display("FAIL frame_after: got en=%0b done=%0b want 0/1", en, done); else n_pass++;
      end
      in_valid = 0;
   endtask

   task automatic test_stall();
      do_reset();
      sram_gnt = 0;
      arm();
      for (int c = 0; c < 10; c++) begin
         in_valid = (c % 2 == 0) && (c < 8); in_pixel = 8'($urandom);
         start = (c == 5);
         tick();
         n_chk++; if (en !== (q.size() != 0) || addr !== m_last[AW+7:8] || d !== m_last[7:0]) $display("FAIL stall_hold c=%0d: got en=%0b %0h/%0h want %0b %0h/%0h", c, en, addr, d, q.size() != 0, m_last[AW+7:8], m_last[7:0]); else n_pass++;
      end
      in_valid = 0; start = 0; sram_gnt = 1;
      for (int c = 0; c < 6; c++) begin
         n_chk++; if (c < 4 && (en !== 1'b1 || addr !== AW'(BASE + c))) $display("FAIL stall_order c=%0d: got en=%0b addr=%0h want 1 %0h", c, en, addr, AW'(BASE + c)); else n_pass++;
         tick();
         n_chk++; if (en !== (q.size() != 0) || d !== m_last[7:0] || wr_count !== AW'(m_wr)) $display("FAIL stall_drain c=%0d: got en=%0b d=%0h cnt=%0d want %0b %0h %0d", c, en, d, wr_count, q.size() != 0, m_last[7:0], m_wr); else n_pass++;
      end
      n_chk++; if (wr_count !== AW'(4) || overflow !== 1'b0) $display("FAIL stall_end: got cnt=%0d ovf=%0b want 4 0", wr_count, overflow); else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      sram_gnt = 0;
      arm();
      for (int c = 0; c < 6; c++) begin
         in_valid = 1; in_pixel = 8'($urandom);
         tick();
      end
      in_valid = 0;
      n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", overflow); else n_pass++;
      n_chk++; if (en !== 1'b1 || addr !== AW'(BASE)) $display("FAIL ovf_head: got en=%0b addr=%0h want 1 %0h", en, addr, AW'(BASE)); else n_pass++;
      sram_gnt = 1;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_chk++; if (en !== (q.size() != 0) || addr !== m_last[AW+7:8] || d !== m_last[7:0]) $display("FAIL ovf_drain c=%0d: got en=%0b %0h/%0h want %0b %0h/%0h", c, en, addr, d, q.size() != 0, m_last[AW+7:8], m_last[7:0]); else n_pass++;
      end
      n_chk++; if (wr_count !== AW'(4) || overflow !== 1'b1) $display("FAIL ovf_cnt: got cnt=%0d ovf=%0b want 4 1", wr_count, overflow); else n_pass++;
      in_valid = 1; in_pixel = 8'h3C;
      tick();
      in_valid = 0;
      n_chk++; if (en !== 1'b1 || addr !== AW'(BASE + 6) || d !== 8'h3C) $display("FAIL ovf_next: got en=%0b %0h/%0h want 1 %0h/3c", en, addr, d, AW'(BASE + 6)); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      sram_gnt = 0;
      arm();
      for (int c = 0; c < 3; c++) begin
         in_valid = 1; in_pixel = 8'($urandom);
         tick();
      end
      in_valid = 0;
      n_chk++; if (en !== 1'b1) $display("FAIL rstmid_pre: got en=%0b want 1", en); else n_pass++;
      rst = 1; sram_gnt = 1;
      tick();
      rst = 0;
      n_chk++; if (en !== 1'b0 || wen !== 1'b1 || addr !== '0 || d !== 8'h00) $display("FAIL rstmid_port: got en=%0b wen=%0b %0h/%0h want 0 1 0/0", en, wen, addr, d); else n_pass++;
      n_chk++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || wr_count !== '0) $display("FAIL rstmid_stat: got busy=%0b done=%0b ovf=%0b cnt=%0d want 0 0 0 0", busy, done, overflow, wr_count); else n_pass++;
      tick();
      n_chk++; if (en !== 1'b0) $display("FAIL rstmid_flushed: got en=%0b want 0", en); else n_pass++;
      arm();
      in_valid = 1; in_pixel = 8'hA5;
      tick();
      in_valid = 0;
      n_chk++; if (en !== 1'b1 || addr !== AW'(BASE) || d !== 8'hA5) $display("FAIL rstmid_rearm: got en=%0b %0h/%0h want 1 %0h/a5", en, addr, d, AW'(BASE)); else n_pass++;
      tick();
   endtask

   task automatic test_random_frame();
      int budget;
      do_reset();
      arm();
      budget = 0;
      while (!m_done && budget < 3000) begin
         in_valid = ($urandom_range(0, 1) == 1); in_pixel = 8'($urandom);
         sram_gnt = ($urandom_range(0, 1) == 1);
         start = ($urandom_range(0, 15) == 0);
         tick();
         budget++;
         n_chk++; if (en !== (q.size() != 0) || addr !== m_last[AW+7:8] || d !== m_last[7:0]) $display("FAIL rand_wr cyc=%0d: got en=%0b %0h/%0h want %0b %0h/%0h", budget, en, addr, d, q.size() != 0, m_last[AW+7:8], m_last[7:0]); else n_pass++;
         n_chk++; if (wr_count !== AW'(m_wr) || overflow !== m_ovf || done !== m_done || busy !== m_run) $display("FAIL rand_stat cyc=%0d: got cnt=%0d ovf=%0b done=%0b busy=%0b want %0d %0b %0b %0b", budget, wr_count, overflow, done, busy, m_wr, m_ovf, m_done, m_run); else n_pass++;
      end
      in_valid = 0; start = 0;
      n_chk++; if (done !== 1'b1) $display("FAIL rand_timeout: got done=%0b want 1 after %0d cycles", done, budget); else n_pass++;
`ifdef WRITE_CHECKSUM_EN
      n_chk++; if (checksum !== 16'(m_sum)) $display("FAIL rand_sum: got %0h want %0h", checksum, 16'(m_sum)); else n_pass++;
`endif
      arm();
      n_chk++; if (done !== 1'b0 || busy !== 1'b1 || wr_count !== '0 || overflow !== 1'b0) $display("FAIL rand_rearm: got done=%0b busy=%0b cnt=%0d ovf=%0b want 0 1 0 0", done, busy, wr_count, overflow); else n_pass++;
   endtask

   initial begin
      rst = 1; start = 0; in_valid = 0; in_pixel = 0; sram_gnt = 0;
      test_reset();
      test_basic();
      test_stall();
      test_overflow();
      test_reset_mid();
      test_full_frame();
      test_random_frame();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
